// File: rtl/pio_ext_pkg.sv
// ============================================================================
// pio_ext_pkg : register addresses and edge-capture modes for pio_ext
// Revision    : 1.0
// ============================================================================
`default_nettype none

package pio_ext_pkg;
  localparam logic [2:0] ADDR_DATA = 3'd0;
  localparam logic [2:0] ADDR_DIR  = 3'd1;
  localparam logic [2:0] ADDR_MASK = 3'd2;
  localparam logic [2:0] ADDR_EDGE = 3'd3;
  localparam logic [2:0] ADDR_SET  = 3'd4;
  localparam logic [2:0] ADDR_CLR  = 3'd5;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;
endpackage

`default_nettype wire

// File: rtl/pio_ext_sync.sv
// ============================================================================
// pio_ext_sync : multi-flop input synchroniser with per-bit edge detection
// Revision     : 1.0
// ============================================================================
`default_nettype none

module pio_ext_sync
  import pio_ext_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] sync_in,
  output logic [WIDTH-1:0] detect
);

  logic [WIDTH-1:0]     stage_q [SYNC_STAGES];
  logic [WIDTH-1:0]     prev_q;
  logic [SYNC_STAGES:0] vld_q;
  logic [WIDTH-1:0]     w_rise;
  logic [WIDTH-1:0]     w_fall;
  logic [WIDTH-1:0]     w_sel;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) stage_q[i] <= '0;
      prev_q <= '0;
      vld_q  <= '0;
    end else begin
      stage_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) stage_q[i] <= stage_q[i-1];
      prev_q <= stage_q[SYNC_STAGES-1];
      vld_q  <= {vld_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign sync_in = stage_q[SYNC_STAGES-1];
  assign w_rise  = sync_in & ~prev_q;
  assign w_fall  = ~sync_in & prev_q;

  generate
    if (EDGE_TYPE == EDGE_RISE) begin : g_rise
      assign w_sel = w_rise;
    end else if (EDGE_TYPE == EDGE_FALL) begin : g_fall
      assign w_sel = w_fall;
    end else begin : g_any
      assign w_sel = w_rise | w_fall;
    end
  endgenerate

  // Detection stays off until prev holds a real sample, so a pin that is
  // high through reset is not mistaken for a rising edge on release.
  assign detect = vld_q[SYNC_STAGES] ? w_sel : '0;

endmodule

`default_nettype wire

// File: rtl/pio_ext.sv
// ============================================================================
// pio_ext : Avalon-MM GPIO port with direction, set/clear, edge capture, irq
// Revision: 1.0
// ============================================================================
`default_nettype none

module pio_ext
  import pio_ext_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_OUT   = '0,
  parameter logic [DATA_WIDTH-1:0] RESET_DIR   = '0,
  parameter int                    EDGE_TYPE   = EDGE_RISE,
  parameter int                    SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  read_n,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic [DATA_WIDTH-1:0] oe_port,
  output logic                  irq
);

  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic [DATA_WIDTH-1:0] dir_q, dir_d;
  logic [DATA_WIDTH-1:0] mask_q, mask_d;
  logic [DATA_WIDTH-1:0] edge_q, edge_d;
  logic [31:0]           readdata_q, readdata_d;
  logic                  irq_q, irq_d;

  logic                  w_wr;
  logic                  w_rd;
  logic [DATA_WIDTH-1:0] w_wd;
  logic [DATA_WIDTH-1:0] w_sync_in;
  logic [DATA_WIDTH-1:0] w_detect;
  logic [31:0]           w_rdata;

  pio_ext_sync #(
    .WIDTH       (DATA_WIDTH),
    .SYNC_STAGES (SYNC_STAGES),
    .EDGE_TYPE   (EDGE_TYPE)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .in_port (in_port),
    .sync_in (w_sync_in),
    .detect  (w_detect)
  );

  assign w_wr = chipselect & ~write_n;
  assign w_rd = chipselect & ~read_n;
  assign w_wd = writedata[DATA_WIDTH-1:0];

  always_comb begin
    data_out_d = data_out_q;
    dir_d      = dir_q;
    mask_d     = mask_q;
    edge_d     = edge_q;
    if (w_wr) begin
      case (address)
        ADDR_DATA: data_out_d = w_wd;
        ADDR_DIR:  dir_d      = w_wd;
        ADDR_MASK: mask_d     = w_wd;
        ADDR_EDGE: edge_d     = edge_q & ~w_wd;
        ADDR_SET:  data_out_d = data_out_q | w_wd;
        ADDR_CLR:  data_out_d = data_out_q & ~w_wd;
        default:   ;
      endcase
    end
    // New edges are OR-ed in after the W1C so a coincident edge survives.
    edge_d = edge_d | w_detect;
    irq_d  = |(edge_q & mask_q);
  end

  always_comb begin
    w_rdata = '0;
    case (address)
      ADDR_DATA: w_rdata[DATA_WIDTH-1:0] = (w_sync_in & ~dir_q) | (data_out_q & dir_q);
      ADDR_DIR:  w_rdata[DATA_WIDTH-1:0] = dir_q;
      ADDR_MASK: w_rdata[DATA_WIDTH-1:0] = mask_q;
      ADDR_EDGE: w_rdata[DATA_WIDTH-1:0] = edge_q;
      default:   ;
    endcase
    readdata_d = w_rd ? w_rdata : readdata_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out_q <= RESET_OUT;
      dir_q      <= RESET_DIR;
      mask_q     <= '0;
      edge_q     <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      data_out_q <= data_out_d;
      dir_q      <= dir_d;
      mask_q     <= mask_d;
      edge_q     <= edge_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  assign readdata = readdata_q;
  assign out_port = data_out_q;
  assign oe_port  = dir_q;
  assign irq      = irq_q;

endmodule

`default_nettype wire

// File: tb/tb_pio_ext.sv
// ============================================================================
// tb_pio_ext : three pio_ext instances (rise/fall/any) against a history model
// Revision   : 1.0
// ============================================================================
`default_nettype none

module tb_pio_ext;
  import pio_ext_pkg::*;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [2:0]    address = '0;
  logic          chipselect = 1'b0;
  logic          read_n = 1'b1;
  logic          write_n = 1'b1;
  logic [31:0]   writedata = '0;
  logic [DW-1:0] in_port = '0;

  // Instance index: 0 = rising, 1 = falling, 2 = any edge
  logic [31:0]   rdata [3];
  logic [DW-1:0] outp  [3];
  logic [DW-1:0] oep   [3];
  logic          irqv  [3];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : g_dut
      pio_ext #(
        .DATA_WIDTH  (DW),
        .RESET_OUT   (8'hA5),
        .RESET_DIR   (8'hFF),
        .EDGE_TYPE   (g),
        .SYNC_STAGES (2)
      ) u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .read_n     (read_n),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (rdata[g]),
        .in_port    (in_port),
        .out_port   (outp[g]),
        .oe_port    (oep[g]),
        .irq        (irqv[g])
      );
    end
  endgenerate

  // Reference model: register map plus a history of pin values seen at
  // each clock edge. A pin value becomes visible two edges after it is
  // sampled, and an edge counts only once three real samples exist.
  logic [DW-1:0] m_dout, m_dir, m_mask;
  logic [DW-1:0] m_edge [3];
  logic          m_irq  [3];
  logic [31:0]   m_rd   [3];
  logic [DW-1:0] h0, h1, h2;
  int            m_cnt;
  logic [DW-1:0] t_rise, t_fall, t_det, t_wd;
  logic          t_wr, t_rd;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_dout <= 8'hA5;
      m_dir  <= 8'hFF;
      m_mask <= '0;
      for (int i = 0; i < 3; i++) begin
        m_edge[i] <= '0;
        m_irq[i]  <= 1'b0;
        m_rd[i]   <= '0;
      end
      h0 <= '0; h1 <= '0; h2 <= '0;
      m_cnt <= 0;
    end else begin
      t_wr   = chipselect && !write_n;
      t_rd   = chipselect && !read_n;
      t_wd   = writedata[DW-1:0];
      t_rise = (m_cnt >= 3) ? (h1 & ~h2) : '0;
      t_fall = (m_cnt >= 3) ? (~h1 & h2) : '0;
      for (int i = 0; i < 3; i++) begin
        t_det = (i == 0) ? t_rise : (i == 1) ? t_fall : (t_rise | t_fall);
        m_irq[i] <= |(m_edge[i] & m_mask);
        if (t_rd) begin
          case (address)
            3'd0:    m_rd[i] <= {24'd0, (h1 & ~m_dir) | (m_dout & m_dir)};
            3'd1:    m_rd[i] <= {24'd0, m_dir};
            3'd2:    m_rd[i] <= {24'd0, m_mask};
            3'd3:    m_rd[i] <= {24'd0, m_edge[i]};
            default: m_rd[i] <= 32'd0;
          endcase
        end
        m_edge[i] <= ((t_wr && address == 3'd3) ? (m_edge[i] & ~t_wd) : m_edge[i]) | t_det;
      end
      if (t_wr) begin
        case (address)
          3'd0: m_dout <= t_wd;
          3'd1: m_dir  <= t_wd;
          3'd2: m_mask <= t_wd;
          3'd4: m_dout <= m_dout | t_wd;
          3'd5: m_dout <= m_dout & ~t_wd;
          default: ;
        endcase
      end
      h2 <= h1; h1 <= h0; h0 <= in_port;
      if (m_cnt < 3) m_cnt <= m_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("out[%0d]", i), {24'd0, outp[i]}, {24'd0, m_dout});
      chk($sformatf("oe[%0d]", i),  {24'd0, oep[i]},  {24'd0, m_dir});
      chk($sformatf("irq[%0d]", i), {31'd0, irqv[i]}, {31'd0, m_irq[i]});
      chk($sformatf("rdata[%0d]", i), rdata[i], m_rd[i]);
    end
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    check_all();
  endtask

  task automatic bus_rd(input logic [2:0] a);
    address = a; chipselect = 1'b1; read_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; read_n = 1'b1;
    check_all();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      check_all();
    end
  endtask

  initial begin
    // Reset values
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out", {24'd0, outp[0]}, 32'hA5);
    chk("rst_oe",  {24'd0, oep[0]},  32'hFF);
    chk("rst_irq", {31'd0, irqv[0]}, 32'd0);
    check_all();
    reset_n = 1'b1;
    bus_rd(ADDR_MASK); chk("rd_mask0", rdata[0], 32'd0);
    bus_rd(ADDR_EDGE); chk("rd_edge0", rdata[0], 32'd0);

    // Output data, set and clear
    bus_wr(ADDR_DATA, 32'h0F); chk("out_wr",  {24'd0, outp[0]}, 32'h0F);
    bus_wr(ADDR_SET,  32'h30); chk("out_set", {24'd0, outp[0]}, 32'h3F);
    bus_wr(ADDR_CLR,  32'h03); chk("out_clr", {24'd0, outp[0]}, 32'h3C);
    bus_rd(ADDR_DATA);         chk("rd_data", rdata[0], 32'h3C);

    // Rising edge on bit2, then unmask
    bus_wr(ADDR_DIR, 32'h00);
    in_port[2] = 1'b1;
    idle(3);
    bus_rd(ADDR_EDGE); chk("cap_rise", rdata[0], 32'h04);
    chk("irq_masked", {31'd0, irqv[0]}, 32'd0);
    bus_wr(ADDR_MASK, 32'h04); chk("irq_lag", {31'd0, irqv[0]}, 32'd0);
    idle(1);                   chk("irq_set", {31'd0, irqv[0]}, 32'd1);

    // W1C clears, irq follows one cycle later
    bus_wr(ADDR_EDGE, 32'h04); chk("irq_hold", {31'd0, irqv[0]}, 32'd1);
    idle(1);                   chk("irq_clr",  {31'd0, irqv[0]}, 32'd0);

    // New edge coinciding with the W1C: set wins
    in_port[2] = 1'b0; idle(4);
    in_port[2] = 1'b1; idle(4);
    chk("irq_again", {31'd0, irqv[0]}, 32'd1);
    in_port[2] = 1'b0; idle(4);
    in_port[2] = 1'b1; idle(2);
    bus_wr(ADDR_EDGE, 32'h04);
    idle(2);
    chk("irq_setwins", {31'd0, irqv[0]}, 32'd1);
    bus_rd(ADDR_EDGE); chk("cap_setwins", rdata[0], 32'h04);

    // Falling / any-edge instances on bit0
    bus_wr(ADDR_MASK, 32'h05);
    bus_wr(ADDR_EDGE, 32'h01);
    in_port[0] = 1'b1; idle(4);
    bus_rd(ADDR_EDGE);
    chk("any_rise",  {31'd0, rdata[2][0]}, 32'd1);
    chk("fall_rise", {31'd0, rdata[1][0]}, 32'd0);
    bus_wr(ADDR_EDGE, 32'h01);
    in_port[0] = 1'b0; idle(4);
    bus_rd(ADDR_EDGE);
    chk("any_fall",  {31'd0, rdata[2][0]}, 32'd1);
    chk("fall_fall", {31'd0, rdata[1][0]}, 32'd1);

    // Asynchronous reset with an edge in flight and irq high
    chk("irq_pre_rst", {31'd0, irqv[0]}, 32'd1);
    in_port[1] = 1'b1;
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("async_irq", {31'd0, irqv[i]}, 32'd0);
      chk("async_rd",  rdata[i], 32'd0);
    end
    @(negedge clk);
    check_all();
    reset_n = 1'b1;
    idle(5);
    bus_rd(ADDR_EDGE);
    for (int i = 0; i < 3; i++) chk("no_cap_after_rst", rdata[i], 32'd0);

    // Randomised traffic
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) in_port = in_port ^ DW'($urandom_range(0, 255));
      case ($urandom_range(0, 2))
        0: bus_wr(3'($urandom_range(0, 7)), $urandom);
        1: bus_rd(3'($urandom_range(0, 7)));
        default: idle(1);
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
